// File: rtl/pkg_2.sv
// Shared constants and types for the RAM port front-ends: data/address sizing,
// per-port latencies, the request record and the scheduler state encoding.
package pkg_2;

  localparam int DATA_WIDTH   = 8;
  localparam int MEM_DEPTH    = 16;
  localparam int ADDR_WIDTH   = $clog2(MEM_DEPTH);

  localparam int RD_LATENCY_A = 2;
  localparam int WR_LATENCY_A = 1;
  localparam int RD_LATENCY_B = 2;
  localparam int WR_LATENCY_B = 1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    STALL
  } sched_state_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO. The head entry is read straight from the storage
// array; full is registered so the upstream ready never sees a combinational path.
module req_fifo
  import pkg_2::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  req_t                   i_push_data,
  input  logic                   i_pop,
  output req_t                   o_head,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q;

  always_comb begin
    // NOTE: default first so every path assigns count_d and no latch is inferred.
    count_d = count_q;
    if (i_push && !i_pop)      count_d = count_q + CNT_W'(1);
    else if (i_pop && !i_push) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (i_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (i_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
      full_q  <= (count_d == CNT_W'(DEPTH));
    end
  end

  // NOTE: storage is not reset; pointers and count alone decide which entries are live.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q] <= i_push_data;
  end

  assign o_head  = mem_q[rd_ptr_q];
  assign o_full  = full_q;
  assign o_empty = (count_q == '0);
  assign o_count = count_q;

endmodule

// File: rtl/port_req_scheduler.sv
// Request front-end for one RAM port: buffers requests, issues one per cycle,
// holds reads behind in-flight writes to the same address, and tags read returns.
module port_req_scheduler #(
  parameter int DATA_WIDTH = pkg_2::DATA_WIDTH,
  parameter int ADDR_WIDTH = pkg_2::ADDR_WIDTH,
  parameter int FIFO_DEPTH = 4,
  parameter int RD_LATENCY = pkg_2::RD_LATENCY_A,
  parameter int WR_LATENCY = pkg_2::WR_LATENCY_A
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_valid,
  output logic                  o_req_ready,
  input  logic                  i_req_we,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [DATA_WIDTH-1:0] i_req_data,
  output logic                  o_mem_en,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_din,
  input  logic [DATA_WIDTH-1:0] i_mem_dout,
  output logic                  o_rsp_valid,
  output logic [ADDR_WIDTH-1:0] o_rsp_addr,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_busy
);

  import pkg_2::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  sched_state_t                            state_q, state_d;
  req_t                                    push_req, head;
  logic                                    push, pop, fifo_full, fifo_empty, hazard;
  logic [CNT_W-1:0]                        fifo_count;
  logic                                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]                   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]                   mem_din_q, mem_din_d;
  logic [WR_LATENCY-1:0]                   wsh_vld_q;
  logic [WR_LATENCY-1:0][ADDR_WIDTH-1:0]   wsh_addr_q;
  logic [RD_LATENCY-1:0]                   rd_vld_q;
  logic [RD_LATENCY-1:0][ADDR_WIDTH-1:0]   rd_addr_q;
  logic                                    rsp_valid_q;
  logic [ADDR_WIDTH-1:0]                   rsp_addr_q;
  logic [DATA_WIDTH-1:0]                   rsp_data_q;

  assign push_req = '{we: i_req_we, addr: i_req_addr, data: i_req_data};
  assign push     = i_req_valid && o_req_ready;

  req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_push      (push),
    .i_push_data (push_req),
    .i_pop       (pop),
    .o_head      (head),
    .o_full      (fifo_full),
    .o_empty     (fifo_empty),
    .o_count     (fifo_count)
  );

  // A head read is unsafe while any write still inside the write latency targets it.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < WR_LATENCY; i++) begin
      if (wsh_vld_q[i] && (wsh_addr_q[i] == head.addr)) hazard = 1'b1;
    end
    hazard = hazard && !head.we && !fifo_empty;
  end

  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = '0;
    if (fifo_empty) begin
      state_d = IDLE;
    end else if (hazard) begin
      state_d = STALL;
    end else begin
      state_d    = ISSUE;
      pop        = 1'b1;
      mem_we_d   = head.we;
      mem_addr_d = head.addr;
      mem_din_d  = head.we ? head.data : '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_din_q   <= '0;
      wsh_vld_q   <= '0;
      wsh_addr_q  <= '0;
      rd_vld_q    <= '0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_addr_q  <= '0;
      rsp_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;

      // Write shadow is loaded together with the port registers, so it covers the issue cycle.
      wsh_vld_q[0]  <= pop && head.we;
      wsh_addr_q[0] <= head.addr;
      for (int i = 1; i < WR_LATENCY; i++) begin
        wsh_vld_q[i]  <= wsh_vld_q[i-1];
        wsh_addr_q[i] <= wsh_addr_q[i-1];
      end

      // Read pipe starts one cycle after issue so its last stage lines up with valid RAM data.
      rd_vld_q[0]  <= o_mem_en && !mem_we_q;
      rd_addr_q[0] <= mem_addr_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_addr_q[i] <= rd_addr_q[i-1];
      end

      rsp_valid_q <= rd_vld_q[RD_LATENCY-1];
      if (rd_vld_q[RD_LATENCY-1]) begin
        rsp_addr_q <= rd_addr_q[RD_LATENCY-1];
        rsp_data_q <= i_mem_dout;
      end
    end
  end

  assign o_req_ready = !fifo_full;
  assign o_mem_en    = (state_q == ISSUE);
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_din   = mem_din_q;
  assign o_rsp_valid = rsp_valid_q;
  assign o_rsp_addr  = rsp_addr_q;
  assign o_rsp_data  = rsp_data_q;
  assign o_busy      = (fifo_count != '0) || o_mem_en || (|rd_vld_q) || (|wsh_vld_q);

endmodule

// File: tb/tb_port_req_scheduler.sv
// Directed and table-driven bench for port_req_scheduler with a small RAM model
// (two-cycle read latency) and an in-order response scoreboard.
module tb_port_req_scheduler;

  logic       i_clk = 1'b0;
  logic       i_rst = 1'b0;
  logic       i_req_valid, i_req_we;
  logic [3:0] i_req_addr;
  logic [7:0] i_req_data;
  logic       o_req_ready, o_mem_en, o_mem_we, o_rsp_valid, o_busy;
  logic [3:0] o_mem_addr, o_rsp_addr;
  logic [7:0] o_mem_din, o_rsp_data, i_mem_dout;

  typedef struct { logic we; logic [3:0] addr; logic [7:0] data; logic [7:0] exp; } vec_t;
  typedef struct { logic [3:0] addr; logic [7:0] data; } rsp_t;
  typedef struct { int cyc; logic we; logic [3:0] addr; } iss_t;

  vec_t       vecs[$];
  rsp_t       exp_q[$];
  iss_t       iss_log[$];
  rsp_t       mon_e;
  logic [7:0] ref_mem [16];
  logic [7:0] ram [16];
  logic [7:0] rd1, rd2;
  int n_chk = 0, n_fail = 0, cyc = 0, rsp_cnt = 0, last_rsp_cyc = 0, reads_sent = 0;
  bit saw_not_ready = 0;

  port_req_scheduler dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_req_valid (i_req_valid),
    .o_req_ready (o_req_ready),
    .i_req_we    (i_req_we),
    .i_req_addr  (i_req_addr),
    .i_req_data  (i_req_data),
    .o_mem_en    (o_mem_en),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_din   (o_mem_din),
    .i_mem_dout  (i_mem_dout),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_addr  (o_rsp_addr),
    .o_rsp_data  (o_rsp_data),
    .o_busy      (o_busy)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  // RAM port model: read data valid two cycles after the issue cycle.
  always @(posedge i_clk) begin
    if (o_mem_en) begin
      if (o_mem_we) ram[o_mem_addr] <= o_mem_din;
      else          rd1 <= ram[o_mem_addr];
    end
    rd2 <= rd1;
  end
  assign i_mem_dout = rd2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (o_mem_en) iss_log.push_back('{cyc, o_mem_we, o_mem_addr});
    if (o_rsp_valid) begin
      rsp_cnt++;
      last_rsp_cyc = cyc;
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL rsp_unexpected: got addr 0x%0h data 0x%0h, expected no response", o_rsp_addr, o_rsp_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_addr", 32'(o_rsp_addr), 32'(mon_e.addr));
        check("rsp_data", 32'(o_rsp_data), 32'(mon_e.data));
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that accepted the request.
  task automatic send(input logic we, input logic [3:0] a, input logic [7:0] d,
                      input bit use_exp, input logic [7:0] exp_d, output int acc_cyc);
    int waited;
    waited = 0;
    i_req_valid = 1'b1; i_req_we = we; i_req_addr = a; i_req_data = d;
    @(negedge i_clk);
    while (!o_req_ready && waited < 64) begin
      saw_not_ready = 1;
      @(negedge i_clk);
      waited++;
    end
    if (!o_req_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: o_req_ready got 0, expected 1 within 64 cycles");
      @(posedge i_clk); #1;
      acc_cyc = cyc;
    end else begin
      @(posedge i_clk); #1;
      acc_cyc = cyc;
      if (we) ref_mem[a] = d;
      else begin
        exp_q.push_back('{a, use_exp ? exp_d : ref_mem[a]});
        reads_sent++;
      end
    end
    i_req_valid = 1'b0;
  endtask

  task automatic drain();
    int w;
    w = 0;
    @(negedge i_clk);
    while (o_busy && w < 300) begin @(negedge i_clk); w++; end
    check("drain_busy", 32'(o_busy), 32'd0);
    repeat (3) @(negedge i_clk);
    check("drain_ready", 32'(o_req_ready), 32'd1);
    @(posedge i_clk); #1;
  endtask

  function automatic void add(input logic we, input logic [3:0] a, input logic [7:0] d, input logic [7:0] e);
    vec_t v;
    v.we = we; v.addr = a; v.data = d; v.exp = e;
    vecs.push_back(v);
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation got past 1 ms, expected to finish earlier");
    $fatal(1);
  end

  initial begin
    int t0, t1, base, nreads, wait_n;
    logic       rwe;
    logic [3:0] ra;
    logic [7:0] rdat;
    i_req_valid = 0; i_req_we = 0; i_req_addr = 0; i_req_data = 0;
    rd1 = 0; rd2 = 0;
    for (int i = 0; i < 16; i++) begin ram[i] = 8'h00; ref_mem[i] = 8'h00; end

    // Reset values
    #1 i_rst = 1'b1;
    #1;
    check("rst_mem_en", 32'(o_mem_en), 32'd0);
    check("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("rst_req_ready", 32'(o_req_ready), 32'd1);
    check("rst_busy", 32'(o_busy), 32'd0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // Directed table: fills, in-order reads 0..5, read-after-write chains
    add(1,0,8'h11,0); add(1,1,8'h22,0); add(1,2,8'h33,0); add(1,3,8'h44,0);
    add(1,4,8'h55,0); add(1,5,8'h66,0);
    add(0,0,0,8'h11); add(0,1,0,8'h22); add(0,2,0,8'h33); add(0,3,0,8'h44);
    add(0,4,0,8'h55); add(0,5,0,8'h66);
    add(1,7,8'h77,0); add(0,7,0,8'h77); add(1,7,8'h88,0); add(1,7,8'h99,0);
    add(0,7,0,8'h99); add(0,8,0,8'h00); add(1,8,8'hC3,0); add(0,8,0,8'hC3);
    add(0,0,0,8'h11);
    base = rsp_cnt; nreads = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      send(vecs[i].we, vecs[i].addr, vecs[i].data, 1'b1, vecs[i].exp, t0);
      if (!vecs[i].we) nreads++;
    end
    drain();
    check("table_rsp_count", 32'(rsp_cnt - base), 32'(nreads));

    // Write then read same address: one stall cycle
    iss_log.delete();
    base = rsp_cnt;
    send(1'b1, 4'd3, 8'hA5, 1'b0, 8'h00, t0);
    send(1'b0, 4'd3, 8'h00, 1'b1, 8'hA5, t1);
    drain();
    check("raw_issue_count", 32'(iss_log.size()), 32'd2);
    check("raw_rsp_count", 32'(rsp_cnt - base), 32'd1);
    if (iss_log.size() == 2) begin
      check("raw_issue_latency", 32'(iss_log[0].cyc - t0), 32'd1);
      check("raw_read_gap", 32'(iss_log[1].cyc - iss_log[0].cyc), 32'd2);
      check("raw_rsp_latency", 32'(last_rsp_cyc - iss_log[1].cyc), 32'd3);
    end

    // Write then read of a different address: no stall
    iss_log.delete();
    send(1'b1, 4'd1, 8'h5A, 1'b0, 8'h00, t0);
    send(1'b0, 4'd2, 8'h00, 1'b0, 8'h00, t1);
    drain();
    check("nohaz_issue_count", 32'(iss_log.size()), 32'd2);
    if (iss_log.size() == 2)
      check("nohaz_gap", 32'(iss_log[1].cyc - iss_log[0].cyc), 32'd1);

    // Repeated write/read pairs to one address build a backlog until the FIFO fills
    saw_not_ready = 0;
    base = rsp_cnt;
    for (int i = 0; i < 8; i++) begin
      send(1'b1, 4'd9, 8'(i + 1), 1'b0, 8'h00, t0);
      send(1'b0, 4'd9, 8'h00, 1'b1, 8'(i + 1), t0);
    end
    drain();
    check("fill_ready_dropped", 32'(saw_not_ready), 32'd1);
    check("fill_rsp_count", 32'(rsp_cnt - base), 32'd8);

    // Mixed random stream against the reference memory
    base = rsp_cnt; nreads = reads_sent;
    for (int i = 0; i < 200; i++) begin
      rwe  = 1'($urandom_range(0, 1));
      ra   = 4'($urandom_range(0, 3));
      rdat = 8'($urandom);
      send(rwe, ra, rdat, 1'b0, 8'h00, t0);
      if ($urandom_range(0, 3) == 0) begin @(posedge i_clk); #1; end
    end
    drain();
    check("rand_rsp_count", 32'(rsp_cnt - base), 32'(reads_sent - nreads));
    check("rand_exp_empty", 32'(exp_q.size()), 32'd0);

    // Reset one cycle after a read issues
    send(1'b0, 4'd6, 8'h00, 1'b0, 8'h00, t0);
    wait_n = 0;
    @(negedge i_clk);
    while (!o_mem_en && wait_n < 10) begin @(negedge i_clk); wait_n++; end
    check("midrst_read_issued", 32'(o_mem_en), 32'd1);
    @(posedge i_clk);
    #2 i_rst = 1'b1;
    #1;
    check("midrst_mem_en", 32'(o_mem_en), 32'd0);
    check("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check("midrst_req_ready", 32'(o_req_ready), 32'd1);
    check("midrst_busy", 32'(o_busy), 32'd0);
    exp_q.delete();
    base = rsp_cnt;
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (8) @(negedge i_clk);
    check("midrst_no_rsp", 32'(rsp_cnt - base), 32'd0);
    check("midrst_busy_after", 32'(o_busy), 32'd0);
    @(posedge i_clk); #1;

    // First request after reset issues the cycle after acceptance
    iss_log.delete();
    send(1'b0, 4'd3, 8'h00, 1'b0, 8'h00, t0);
    drain();
    check("post_rst_issue_count", 32'(iss_log.size()), 32'd1);
    if (iss_log.size() == 1)
      check("post_rst_issue_latency", 32'(iss_log[0].cyc - t0), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
